// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
// Shares an intersection between NS vehicles, EW vehicles and pedestrians,
// with emergency preemption. Green phases use gap-out/max-out timing, and
// normal requests are served round-robin. Lamp outputs are Moore decodes of
// the state register.
//
// Optional build macro PED_FLASH_EN: PED_WALK is followed by a PED_CLEAR
// phase with a flashing don't-walk. When the macro is undefined, PED_CLEAR
// does not exist and ped_flash is tied to 0.
//
// Handshake: there is no valid/ready traffic here. Requests are levels,
// except ped_req, which may be a 1-cycle pulse and is latched into ped_pend.
// ped_ack is a registered 1-cycle pulse in the first PED_WALK cycle.
module intersection_phase_scheduler #(
    parameter int unsigned GREEN_MIN      = 4,
    parameter int unsigned GREEN_MAX      = 10,
    parameter int unsigned YELLOW_TIME    = 2,
    parameter int unsigned ALLRED_TIME    = 1,
    parameter int unsigned WALK_TIME      = 6,
    parameter int unsigned PED_CLEAR_TIME = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_req,
    input  logic       emerg_req,
    input  logic       emerg_dir,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_flash,
    output logic       ped_ack,
    output logic [2:0] phase
);

    // The timer is sized from the largest duration parameter.
    localparam int unsigned MAX_A = (GREEN_MIN > GREEN_MAX) ? GREEN_MIN : GREEN_MAX;
    localparam int unsigned MAX_B = (YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME : ALLRED_TIME;
    localparam int unsigned MAX_C = (WALK_TIME > PED_CLEAR_TIME) ? WALK_TIME : PED_CLEAR_TIME;
    localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_P = (MAX_C > MAX_D) ? MAX_C : MAX_D;
    localparam int unsigned TW    = $clog2(MAX_P + 1);

    localparam logic [TW-1:0] T_GMIN   = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] T_GMAX   = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_TIME - 1);
    localparam logic [TW-1:0] T_WALK   = TW'(WALK_TIME - 1);
    localparam logic [TW-1:0] T_SAT    = '1;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [2:0] {
        S_ALLRED    = 3'd0,
        S_NS_GREEN  = 3'd1,
        S_NS_YELLOW = 3'd2,
        S_EW_GREEN  = 3'd3,
        S_EW_YELLOW = 3'd4,
        S_PED_WALK  = 3'd5,
        S_PED_CLEAR = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        RR_NS  = 2'd0,
        RR_EW  = 2'd1,
        RR_PED = 2'd2
    } rr_t;

    state_t        state_q, state_d;
    rr_t           rr_q, rr_d;
    logic [TW-1:0] timer_q;
    logic          ped_pend_q;
    logic          ped_ack_q;

    rr_t           rr_grant;
    logic          rr_any;
    logic          ns_comp;
    logic          ew_comp;
    logic          walk_entry;

    // Round-robin pick among pending requests, searching after the last grant.
    always_comb begin
        rr_grant = RR_NS;
        rr_any   = 1'b1;
        case (rr_q)
            RR_NS: begin
                if (req_ew)          rr_grant = RR_EW;
                else if (ped_pend_q) rr_grant = RR_PED;
                else if (req_ns)     rr_grant = RR_NS;
                else                 rr_any   = 1'b0;
            end
            RR_EW: begin
                if (ped_pend_q)      rr_grant = RR_PED;
                else if (req_ns)     rr_grant = RR_NS;
                else if (req_ew)     rr_grant = RR_EW;
                else                 rr_any   = 1'b0;
            end
            default: begin
                if (req_ns)          rr_grant = RR_NS;
                else if (req_ew)     rr_grant = RR_EW;
                else if (ped_pend_q) rr_grant = RR_PED;
                else                 rr_any   = 1'b0;
            end
        endcase
    end

    assign ns_comp = req_ew | ped_pend_q;
    assign ew_comp = req_ns | ped_pend_q;

    // Next-state selection and round-robin pointer update.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            S_ALLRED: begin
                if (timer_q == T_ALLRED) begin
                    if (emerg_req) begin
                        // Preemption overrides fairness; the pointer still
                        // records the last phase that was granted.
                        state_d = emerg_dir ? S_EW_GREEN : S_NS_GREEN;
                        rr_d    = emerg_dir ? RR_EW : RR_NS;
                    end else if (rr_any) begin
                        rr_d = rr_grant;
                        case (rr_grant)
                            RR_NS:   state_d = S_NS_GREEN;
                            RR_EW:   state_d = S_EW_GREEN;
                            default: state_d = S_PED_WALK;
                        endcase
                    end else begin
                        // Nothing is pending, so rest in NS green.
                        state_d = S_NS_GREEN;
                        rr_d    = RR_NS;
                    end
                end
            end
            S_NS_GREEN: begin
                if (emerg_req) begin
                    if (emerg_dir) state_d = S_NS_YELLOW;
                end else if (ns_comp) begin
                    if (!req_ns && (timer_q >= T_GMIN)) state_d = S_NS_YELLOW;
                    if (req_ns && (timer_q >= T_GMAX))  state_d = S_NS_YELLOW;
                end
            end
            S_EW_GREEN: begin
                if (emerg_req) begin
                    if (!emerg_dir) state_d = S_EW_YELLOW;
                end else if (ew_comp) begin
                    if (!req_ew && (timer_q >= T_GMIN)) state_d = S_EW_YELLOW;
                    if (req_ew && (timer_q >= T_GMAX))  state_d = S_EW_YELLOW;
                end
            end
            S_NS_YELLOW: begin
                if (timer_q == T_YELLOW) state_d = S_ALLRED;
            end
            S_EW_YELLOW: begin
                if (timer_q == T_YELLOW) state_d = S_ALLRED;
            end
            S_PED_WALK: begin
                if (emerg_req) begin
                    state_d = S_ALLRED;
                end else if (timer_q == T_WALK) begin
`ifdef PED_FLASH_EN
                    state_d = S_PED_CLEAR;
`else
                    state_d = S_ALLRED;
`endif
                end
            end
`ifdef PED_FLASH_EN
            S_PED_CLEAR: begin
                if (emerg_req || (timer_q == TW'(PED_CLEAR_TIME - 1))) state_d = S_ALLRED;
            end
`endif
            default: state_d = S_ALLRED;
        endcase
    end

    assign walk_entry = (state_d == S_PED_WALK) && (state_q != S_PED_WALK);

    // State, pointer, phase timer, pedestrian latch and ack pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ALLRED;
            rr_q       <= RR_NS;
            timer_q    <= '0;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (state_d != state_q)  timer_q <= '0;
            else if (timer_q != T_SAT) timer_q <= timer_q + 1'b1;
            // A button press in the entry cycle stays pending for a later walk.
            if (walk_entry)   ped_pend_q <= ped_req;
            else if (ped_req) ped_pend_q <= 1'b1;
            ped_ack_q <= walk_entry;
        end
    end

    // Moore lamp decode from the state register.
    always_comb begin
        ns_light  = LAMP_RED;
        ew_light  = LAMP_RED;
        walk      = 1'b0;
        ped_flash = 1'b0;
        case (state_q)
            S_NS_GREEN:  ns_light = LAMP_GREEN;
            S_NS_YELLOW: ns_light = LAMP_YELLOW;
            S_EW_GREEN:  ew_light = LAMP_GREEN;
            S_EW_YELLOW: ew_light = LAMP_YELLOW;
            S_PED_WALK:  walk     = 1'b1;
`ifdef PED_FLASH_EN
            S_PED_CLEAR: ped_flash = ~timer_q[0];
`endif
            default: ;
        endcase
    end

    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler: reset, rest-in-green,
// max-out, gap-out, pedestrian service, emergency preemption and reset
// during yellow with a pending pedestrian request.
module tb_intersection_phase_scheduler;

    localparam logic [2:0] PH_ALLRED   = 3'd0;
    localparam logic [2:0] PH_NS_G     = 3'd1;
    localparam logic [2:0] PH_NS_Y     = 3'd2;
    localparam logic [2:0] PH_EW_G     = 3'd3;
    localparam logic [2:0] PH_EW_Y     = 3'd4;
    localparam logic [2:0] PH_WALK     = 3'd5;
    localparam logic [2:0] PH_CLEAR    = 3'd6;
    localparam logic [2:0] RED         = 3'b100;
    localparam logic [2:0] YEL         = 3'b010;
    localparam logic [2:0] GRN         = 3'b001;

    logic       clk;
    logic       reset;
    logic       req_ns;
    logic       req_ew;
    logic       ped_req;
    logic       emerg_req;
    logic       emerg_dir;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_flash;
    logic       ped_ack;
    logic [2:0] phase;

    int n_checks = 0;
    int n_pass   = 0;

    intersection_phase_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req_ns    (req_ns),
        .req_ew    (req_ew),
        .ped_req   (ped_req),
        .emerg_req (emerg_req),
        .emerg_dir (emerg_dir),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .walk      (walk),
        .ped_flash (ped_flash),
        .ped_ack   (ped_ack),
        .phase     (phase)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input logic [2:0] ph, input logic [2:0] ns,
                             input logic [2:0] ew, input logic wk);
        chk({tag, "_phase"}, {5'd0, phase}, {5'd0, ph});
        chk({tag, "_ns"}, {5'd0, ns_light}, {5'd0, ns});
        chk({tag, "_ew"}, {5'd0, ew_light}, {5'd0, ew});
        chk({tag, "_walk"}, {7'd0, walk}, {7'd0, wk});
    endtask

    // Directed stimulus sequence.
    initial begin
        reset     = 1'b1;
        req_ns    = 1'b0;
        req_ew    = 1'b0;
        ped_req   = 1'b0;
        emerg_req = 1'b0;
        emerg_dir = 1'b0;
        repeat (2) tick();
        chk_state("rst", PH_ALLRED, RED, RED, 1'b0);
        chk("rst_flash", {7'd0, ped_flash}, 8'd0);
        chk("rst_ack", {7'd0, ped_ack}, 8'd0);

        // 1: only NS demand -> one all-red cycle, then rest in NS green.
        req_ns = 1'b1;
        reset  = 1'b0;
        chk_state("t1_allred", PH_ALLRED, RED, RED, 1'b0);
        tick();
        chk_state("t1_green", PH_NS_G, GRN, RED, 1'b0);
        repeat (30) tick();
        chk_state("t1_rest", PH_NS_G, GRN, RED, 1'b0);

        // 2: both directions demand -> NS max-out after 10 green cycles.
        apply_reset();
        tick();
        chk_state("t2_green_c0", PH_NS_G, GRN, RED, 1'b0);
        req_ew = 1'b1;
        repeat (9) tick();
        chk_state("t2_green_c9", PH_NS_G, GRN, RED, 1'b0);
        tick();
        chk_state("t2_yellow_c0", PH_NS_Y, YEL, RED, 1'b0);
        tick();
        chk_state("t2_yellow_c1", PH_NS_Y, YEL, RED, 1'b0);
        tick();
        chk_state("t2_allred", PH_ALLRED, RED, RED, 1'b0);
        tick();
        chk_state("t2_ew_green", PH_EW_G, RED, GRN, 1'b0);

        // 3: idle NS green, EW demand at cycle 1 -> gap-out after 4 cycles.
        req_ns = 1'b0;
        req_ew = 1'b0;
        apply_reset();
        tick();
        chk_state("t3_green_c0", PH_NS_G, GRN, RED, 1'b0);
        tick();
        req_ew = 1'b1;
        tick();
        tick();
        chk_state("t3_green_c3", PH_NS_G, GRN, RED, 1'b0);
        tick();
        chk_state("t3_yellow", PH_NS_Y, YEL, RED, 1'b0);

        // 4: pedestrian pulse during EW green -> walk phase, then NS.
        req_ns = 1'b1;
        tick();
        tick();
        chk_state("t4_allred0", PH_ALLRED, RED, RED, 1'b0);
        tick();
        chk_state("t4_ew_green", PH_EW_G, RED, GRN, 1'b0);
        req_ew  = 1'b0;
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        tick();
        tick();
        chk_state("t4_ew_c3", PH_EW_G, RED, GRN, 1'b0);
        tick();
        chk_state("t4_ew_yellow", PH_EW_Y, RED, YEL, 1'b0);
        tick();
        tick();
        chk_state("t4_allred1", PH_ALLRED, RED, RED, 1'b0);
        tick();
        chk_state("t4_walk_c0", PH_WALK, RED, RED, 1'b1);
        chk("t4_ack_on", {7'd0, ped_ack}, 8'd1);
        chk("t4_flash_walk", {7'd0, ped_flash}, 8'd0);
        tick();
        chk("t4_ack_off", {7'd0, ped_ack}, 8'd0);
        chk_state("t4_walk_c1", PH_WALK, RED, RED, 1'b1);
        repeat (4) tick();
        chk_state("t4_walk_c5", PH_WALK, RED, RED, 1'b1);
        tick();
`ifdef PED_FLASH_EN
        chk_state("t4_clear_c0", PH_CLEAR, RED, RED, 1'b0);
        chk("t4_flash_c0", {7'd0, ped_flash}, 8'd1);
        tick();
        chk("t4_flash_c1", {7'd0, ped_flash}, 8'd0);
        tick();
        chk("t4_flash_c2", {7'd0, ped_flash}, 8'd1);
        tick();
`endif
        chk_state("t4_allred2", PH_ALLRED, RED, RED, 1'b0);
        chk("t4_ack_quiet", {7'd0, ped_ack}, 8'd0);
        tick();
        chk_state("t4_ns_green", PH_NS_G, GRN, RED, 1'b0);

        // 5: EW preemption during NS green cycle 1.
        tick();
        emerg_req = 1'b1;
        emerg_dir = 1'b1;
        tick();
        chk_state("t5_yellow_c0", PH_NS_Y, YEL, RED, 1'b0);
        tick();
        chk_state("t5_yellow_c1", PH_NS_Y, YEL, RED, 1'b0);
        tick();
        chk_state("t5_allred", PH_ALLRED, RED, RED, 1'b0);
        tick();
        chk_state("t5_ew_green", PH_EW_G, RED, GRN, 1'b0);
        repeat (15) tick();
        chk_state("t5_hold", PH_EW_G, RED, GRN, 1'b0);
        emerg_req = 1'b0;
        emerg_dir = 1'b0;
        tick();
        chk_state("t5_resume", PH_EW_Y, RED, YEL, 1'b0);

        // 6: reset during NS yellow with a pending pedestrian request.
        tick();
        tick();
        chk_state("t6_allred", PH_ALLRED, RED, RED, 1'b0);
        tick();
        chk_state("t6_ns_green", PH_NS_G, GRN, RED, 1'b0);
        req_ns  = 1'b0;
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        tick();
        tick();
        tick();
        chk_state("t6_yellow", PH_NS_Y, YEL, RED, 1'b0);
        reset = 1'b1;
        #1;
        chk_state("t6_in_reset", PH_ALLRED, RED, RED, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk_state("t6_after", PH_NS_G, GRN, RED, 1'b0);
        repeat (10) tick();
        chk_state("t6_no_walk", PH_NS_G, GRN, RED, 1'b0);
        chk("t6_ack", {7'd0, ped_ack}, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Scheduler that shares the intersection between three normal requesters (NS vehicles, EW vehicles, pedestrians) and one emergency-preemption input.
- Decides which phase gets the right-of-way and for how long, using gap-out/max-out green timing and round-robin fairness.
- Drives the NS/EW lamp vectors and the walk signal.
- Sits between the loop detectors, ped buttons and preemption receiver, and the lamp drivers.

Parameters:
GREEN_MIN, 4, min green cycles before yielding to a competing request
GREEN_MAX, 10, max green cycles while own request persists and a competitor waits
YELLOW_TIME, 2, yellow cycles
ALLRED_TIME, 1, all-red clearance cycles between every phase
WALK_TIME, 6, pedestrian walk cycles
PED_CLEAR_TIME, 3, flashing clearance cycles (used only with PED_FLASH_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_ns  in  1  NS vehicle demand, level
req_ew  in  1  EW vehicle demand, level
ped_req  in  1  pedestrian button, single-cycle pulse allowed
emerg_req  in  1  emergency preemption, level
emerg_dir  in  1  preempting direction: 0=NS, 1=EW
ns_light  out  3  {Red,Yellow,Green}, one-hot
ew_light  out  3  {Red,Yellow,Green}, one-hot
walk  out  1  pedestrian walk lamp
ped_flash  out  1  flashing don't-walk
ped_ack  out  1  1-cycle pulse on entry to PED_WALK
phase  out  3  current state encoding, for debug

Behaviour:
- Reset (async, active-high): state=ALLRED, timer=0, ped_pend=0, rr_ptr=NS. Both lights 3'b100; walk, ped_flash, ped_ack all 0.
- States: ALLRED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK, plus PED_CLEAR (macro only).
- Outputs are Moore decodes of the state register; ped_ack is registered.
- Timer: resets to 0 on each state entry and increments each cycle. A state of duration N exits at the edge where timer==N-1. The timer saturates at its maximum value and never wraps. Width is ceil(log2(max parameter+1)).
- ped_pend: set by ped_req, cleared on PED_WALK entry. ped_req arriving in the same cycle as PED_WALK entry leaves ped_pend set.
- Green-state exit rules. "Own" = own direction's req; "competitor" = other direction's req OR ped_pend.
  - Emergency request for the other direction: go to yellow next edge, min green bypassed.
  - Emergency request for own direction: hold green while emerg_req=1.
  - Competitor present and own req=0: exit once timer>=GREEN_MIN-1 (gap-out).
  - Competitor present and own req=1: exit once timer>=GREEN_MAX-1 (max-out).
  - No competitor: hold green indefinitely (rest in green).
- Yellow: exit to ALLRED after YELLOW_TIME cycles. Yellow is never aborted or extended.
- PED_WALK: exit after WALK_TIME cycles to ALLRED (or PED_CLEAR with macro). emerg_req=1 aborts to ALLRED next edge.
- ALLRED: after ALLRED_TIME cycles, select the next phase in this priority order:
  - emerg_req: green for emerg_dir.
  - Otherwise round-robin over {NS, EW, PED}, starting after rr_ptr, among pending requests. rr_ptr updates to the phase granted.
  - Nothing pending: NS_GREEN.
- emerg_dir is sampled every cycle. A change while holding green is treated as a new emergency request for the other direction.
- Exactly one direction may be non-red at any time; walk=1 only when both directions are red.

Optional Feature:
PED_FLASH_EN: when defined, PED_WALK exits to PED_CLEAR.
- PED_CLEAR: walk=0, both directions red, ped_flash toggles each cycle starting at 1.
- Exits to ALLRED after PED_CLEAR_TIME cycles; emerg_req aborts it next edge.
When undefined: PED_CLEAR does not exist and ped_flash is tied 0.

Test Plan:
1. Reset release, req_ns=1 only -> 1 cycle all-red, then NS green held for >=30 cycles; ew_light=100, walk=0.
2. req_ns=1 held; req_ew=1 from NS-green cycle 0 -> NS green 10 cycles, yellow 2, all-red 1, EW green.
3. req_ns=0; req_ew=1 raised at NS-green cycle 1 -> NS green exactly 4 cycles, then yellow.
4. req_ns=1; 1-cycle ped_req during EW green -> EW yellow, all-red, PED_WALK 6 cycles with one ped_ack pulse on entry, all-red, NS green. With macro, a 3-cycle PED_CLEAR (ped_flash 1,0,1) precedes the all-red.
5. During NS green cycle 1, emerg_req=1, emerg_dir=1 -> NS_YELLOW next edge, 2 yellow, 1 all-red, EW green held while emerg_req=1. Deassert -> normal gap-out/max-out resumes.
6. Assert reset mid NS_YELLOW with ped_pend=1 -> same cycle: all lamps red, walk=0; after release, ped_pend=0 and no PED_WALK occurs.
